// File: rtl/adsb_ts_packer.sv
// rtl/adsb_ts_packer.sv - PPS timestamp to drift-corrected nanosecond word packer with output FIFO
module adsb_ts_packer #(
    parameter int UTC_SECONDS_WIDTH       = 6,
    parameter int COUNT_LAST_SECOND_WIDTH = 26,
    parameter int DRIFT_COUNT_WIDTH       = 13,
    parameter int NOMINAL_CYCLES_PER_SEC  = 61_440_000,
    parameter int DRIFT_LIMIT             = 2048,
    parameter int FIFO_DEPTH              = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ts_ready,
    input  logic [UTC_SECONDS_WIDTH-1:0]       ts_utc_seconds,
    input  logic [COUNT_LAST_SECOND_WIDTH-1:0] ts_clk_counter,
    input  logic [DRIFT_COUNT_WIDTH-1:0]       ts_drift,
    input  logic                               rd_en,
    output logic [63:0]                        rd_data,
    output logic                               empty,
    output logic                               full,
    output logic [15:0]                        drop_count,
    input  logic                               clear_drops,
    output logic                               busy
);
    localparam int CW     = COUNT_LAST_SECOND_WIDTH;
    localparam int NS_W   = 30;
    localparam int PROD_W = CW + NS_W;
    localparam int DIV_W  = 27;
    localparam int AW     = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_PUSH} state_t;

    state_t                       state_q;
    logic [UTC_SECONDS_WIDTH-1:0] sec_q, pend_sec_q;
    logic [CW-1:0]                cnt_q, pend_cnt_q;
    logic [DRIFT_COUNT_WIDTH-1:0] drift_q, pend_drift_q;
    logic                         pend_valid_q;
    logic [DIV_W-1:0]             div_q, rem_q;
    logic [NS_W-1:0]              lo_q, quo_q;
    logic [4:0]                   iter_q;
    logic                         sat_q, bad_q;

    logic [AW:0]                  wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic                         empty_q, full_q;
    logic [63:0]                  mem_q [FIFO_DEPTH];
    logic [15:0]                  drop_q;

    logic signed [31:0] drift_ext;
    logic               drift_bad_c;
    logic [DIV_W-1:0]   div_c;
    logic [PROD_W-1:0]  prod_c;
    logic [DIV_W:0]     trial;
    logic               ge;
    logic [DIV_W-1:0]   diff;
    logic [63:0]        word_c;

    assign drift_ext   = 32'($signed(drift_q));
    assign drift_bad_c = (drift_ext > DRIFT_LIMIT) || (drift_ext < -DRIFT_LIMIT);
    assign div_c       = drift_bad_c ? DIV_W'(NOMINAL_CYCLES_PER_SEC)
                                     : DIV_W'(NOMINAL_CYCLES_PER_SEC) + DIV_W'(drift_ext);
    assign prod_c      = PROD_W'(cnt_q) * PROD_W'(1_000_000_000);

    // Restoring step: shift in the next product bit, subtract when the divisor fits.
    assign trial = {rem_q, lo_q[NS_W-1]};
    assign ge    = trial >= {1'b0, div_q};
    assign diff  = trial[DIV_W-1:0] - div_q;
    assign word_c = {sec_q, sat_q, bad_q, cnt_q, sat_q ? NS_W'(999_999_999) : quo_q};

    logic idle_c, push_cyc, take_direct, take_pend, strobe_drop;
    logic pop, fifo_wr, fifo_drop;

    assign idle_c      = (state_q == S_IDLE);
    assign push_cyc    = (state_q == S_PUSH);
    assign busy        = !idle_c;
    assign take_direct = ts_ready && (idle_c || (push_cyc && !pend_valid_q));
    assign take_pend   = ts_ready && busy && !take_direct && (!pend_valid_q || push_cyc);
    assign strobe_drop = ts_ready && !take_direct && !take_pend;

    assign pop       = rd_en && !empty_q;
    assign fifo_wr   = push_cyc && (!full_q || pop);
    assign fifo_drop = push_cyc && full_q && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sec_q        <= '0;
            cnt_q        <= '0;
            drift_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_sec_q   <= '0;
            pend_cnt_q   <= '0;
            pend_drift_q <= '0;
            div_q        <= '0;
            rem_q        <= '0;
            lo_q         <= '0;
            quo_q        <= '0;
            iter_q       <= '0;
            sat_q        <= 1'b0;
            bad_q        <= 1'b0;
        end else begin
            if (take_pend) begin
                pend_valid_q <= 1'b1;
                pend_sec_q   <= ts_utc_seconds;
                pend_cnt_q   <= ts_clk_counter;
                pend_drift_q <= ts_drift;
            end else if (push_cyc && pend_valid_q) begin
                pend_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (take_direct) begin
                        sec_q   <= ts_utc_seconds;
                        cnt_q   <= ts_clk_counter;
                        drift_q <= ts_drift;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    div_q   <= div_c;
                    bad_q   <= drift_bad_c;
                    sat_q   <= DIV_W'(cnt_q) >= div_c;
                    rem_q   <= DIV_W'(prod_c[PROD_W-1:NS_W]);
                    lo_q    <= prod_c[NS_W-1:0];
                    quo_q   <= '0;
                    iter_q  <= '0;
                    state_q <= S_DIV;
                end
                S_DIV: begin
                    rem_q  <= ge ? diff : trial[DIV_W-1:0];
                    lo_q   <= {lo_q[NS_W-2:0], 1'b0};
                    quo_q  <= {quo_q[NS_W-2:0], ge};
                    iter_q <= iter_q + 5'd1;
                    if (iter_q == 5'(NS_W - 1)) state_q <= S_PUSH;
                end
                default: begin
                    if (pend_valid_q) begin
                        sec_q   <= pend_sec_q;
                        cnt_q   <= pend_cnt_q;
                        drift_q <= pend_drift_q;
                        state_q <= S_LOAD;
                    end else if (take_direct) begin
                        sec_q   <= ts_utc_seconds;
                        cnt_q   <= ts_clk_counter;
                        drift_q <= ts_drift;
                        state_q <= S_LOAD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, fifo_wr};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= (wr_ptr_d == rd_ptr_d);
            full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) mem_q[wr_ptr_q[AW-1:0]] <= word_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (clear_drops) begin
            drop_q <= '0;
        end else if ((strobe_drop || fifo_drop) && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign rd_data    = empty_q ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign empty      = empty_q;
    assign full       = full_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_adsb_ts_packer.sv
// tb/tb_adsb_ts_packer.sv - scoreboard bench for adsb_ts_packer against an arithmetic reference model
module tb_adsb_ts_packer;
    localparam longint NOMINAL = 61_440_000;
    localparam int     DLIM    = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        ts_ready;
    logic [5:0]  ts_utc_seconds;
    logic [25:0] ts_clk_counter;
    logic [12:0] ts_drift;
    logic        rd_en;
    logic [63:0] rd_data;
    logic        empty, full, busy;
    logic [15:0] drop_count;
    logic        clear_drops;

    logic mon_rd = 1'b0, tb_rd = 1'b0, auto_en = 1'b0;
    assign rd_en = mon_rd | tb_rd;

    int checks = 0, errors = 0;
    logic [63:0] sb[$];
    int edge_n = 0;
    longint s_last = -1000;
    bit pend = 1'b0;
    int model_drops = 0;

    adsb_ts_packer dut (
        .clk(clk), .rst(rst), .ts_ready(ts_ready), .ts_utc_seconds(ts_utc_seconds),
        .ts_clk_counter(ts_clk_counter), .ts_drift(ts_drift), .rd_en(rd_en),
        .rd_data(rd_data), .empty(empty), .full(full), .drop_count(drop_count),
        .clear_drops(clear_drops), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_word(input int sec, input int count, input int drift);
        bit bad, sat;
        longint d, ns;
        bad = (drift > DLIM) || (drift < -DLIM);
        d   = bad ? NOMINAL : NOMINAL + longint'(drift);
        sat = longint'(count) >= d;
        ns  = sat ? 64'd999_999_999 : (longint'(count) * 1_000_000_000) / d;
        return {6'(sec), sat, bad, 26'(count), 30'(ns)};
    endfunction

    // Engine occupancy model: each conversion owns 32 edges; one strobe may wait behind it.
    task automatic model_accept(input longint t, output bit acc);
        if (pend && t > s_last + 32) begin
            s_last = s_last + 32;
            pend   = 1'b0;
        end
        acc = 1'b1;
        if (!pend && t >= s_last + 32) s_last = t;
        else if (pend && t == s_last + 32) s_last = t;
        else if (!pend) pend = 1'b1;
        else acc = 1'b0;
    endtask

    // mode 0: normal, 1: lost to a full FIFO, 2: aborted by reset
    task automatic strobe(input int sec, input int count, input int drift, input int mode);
        bit acc;
        @(negedge clk);
        ts_ready = 1'b1;
        ts_utc_seconds = 6'(sec);
        ts_clk_counter = 26'(count);
        ts_drift = 13'(drift);
        model_accept(longint'(edge_n + 1), acc);
        if (!acc || mode == 1) model_drops++;
        else if (mode == 0) sb.push_back(model_word(sec, count, drift));
        @(negedge clk);
        ts_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic drain();
        auto_en = 1'b1;
        for (int i = 0; i < 2000 && (sb.size() != 0 || !empty || busy); i++) @(negedge clk);
        check("drain_scoreboard", 64'(sb.size()), 64'd0);
        check("drain_empty", 64'(empty), 64'd1);
    endtask

    initial begin : monitor
        logic [63:0] exp;
        forever begin
            @(negedge clk);
            mon_rd = auto_en && !empty;
            #1;
            if (rd_en === 1'b1 && empty === 1'b0 && rst === 1'b0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h expected=none", rd_data);
                end else begin
                    exp = sb.pop_front();
                    check("word", rd_data, exp);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; ts_ready = 1'b0; ts_utc_seconds = '0; ts_clk_counter = '0; ts_drift = '0;
        clear_drops = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_drops", 64'(drop_count), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Latency: word visible 32 edges after the strobe edge.
        auto_en = 1'b0;
        strobe(17, 30_720_000, 0, 0);
        check("busy_after_strobe", 64'(busy), 64'd1);
        repeat (31) @(negedge clk);
        check("empty_before_push", 64'(empty), 64'd1);
        @(negedge clk);
        check("empty_after_push", 64'(empty), 64'd0);
        drain();

        strobe(3, 61_439_999, 0, 0);      wait_idle();
        strobe(4, 30_719_980, -40, 0);    wait_idle();
        strobe(5, 61_440_000, 0, 0);      wait_idle();
        strobe(6, 30_000_000, 3000, 0);   wait_idle();
        strobe(7, 1_000_000, -2048, 0);   wait_idle();
        strobe(8, 1_000_000, -2049, 0);   wait_idle();
        drain();

        // Pending slot: third strobe lost.
        strobe(10, 100, 0, 0);
        strobe(11, 200, 0, 0);
        strobe(12, 300, 0, 0);
        wait_idle(); wait_idle();
        check("drops_three_strobes", 64'(drop_count), 64'(model_drops));
        @(negedge clk); clear_drops = 1'b1;
        @(negedge clk); clear_drops = 1'b0;
        check("drops_cleared", 64'(drop_count), 64'd0);
        model_drops = 0;
        drain();

        // Full FIFO behaviour.
        auto_en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            strobe(20 + i, 1_000_000 * (i + 1), i * 10, 0);
            wait_idle();
        end
        check("full_after_8", 64'(full), 64'd1);
        strobe(40, 5_000_000, 0, 1);
        wait_idle();
        check("drop_fifo_full", 64'(drop_count), 64'd1);
        check("still_full", 64'(full), 64'd1);
        strobe(41, 6_000_000, 0, 0);
        repeat (31) @(negedge clk);
        tb_rd = 1'b1;
        @(negedge clk);
        tb_rd = 1'b0;
        check("full_after_pop_push", 64'(full), 64'd1);
        check("drop_no_change", 64'(drop_count), 64'd1);
        drain();

        // Reset in the middle of the divide.
        strobe(50, 40_000_000, 7, 2);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_empty", 64'(empty), 64'd1);
        check("abort_full", 64'(full), 64'd0);
        check("abort_drops", 64'(drop_count), 64'd0);
        check("abort_rd_data", rd_data, 64'd0);
        s_last = -1000; pend = 1'b0; model_drops = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_write", 64'(empty), 64'd1);
        strobe(51, 12_345_678, 100, 0);
        wait_idle();
        drain();

        // Randomised traffic with overlapping strobes.
        for (int i = 0; i < 30; i++) begin
            int gap, drift, count;
            gap   = int'($urandom_range(0, 40));
            drift = int'($urandom_range(0, 8191)) - 4096;
            count = int'($urandom_range(0, 62_000_000));
            strobe(int'($urandom_range(0, 59)), count, drift, 0);
            repeat (gap) @(negedge clk);
        end
        wait_idle(); wait_idle();
        drain();
        check("random_drops", 64'(drop_count), 64'(model_drops));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adsb_ts_packer.md
# adsb_ts_packer

Consumes the one-cycle `ready` strobe and captured timestamp (UTC second, clock count since PPS, last-second drift) from the PPS timestamp stage. Converts the clock count to drift-corrected nanoseconds within the second with a sequential divider. Packs the result into a 64-bit word and buffers it in a small show-ahead FIFO for the processor-side reader. Sits between the PPS timestamp stage and the ADS-B message/register interface.

## Interface
- `UTC_SECONDS_WIDTH`, 6: width of UTC-second field.
- `COUNT_LAST_SECOND_WIDTH`, 26: width of clock-count input.
- `DRIFT_COUNT_WIDTH`, 13: width of signed drift input.
- `NOMINAL_CYCLES_PER_SEC`, 61_440_000: nominal clk cycles per PPS second.
- `DRIFT_LIMIT`, 2048: maximum accepted |drift| in cycles.
- `FIFO_DEPTH`, 8: output FIFO entries; must be a power of 2, ≥2.
- `clk  in  1`: system clock.
- `rst  in  1`: asynchronous, active-high reset.
- `ts_ready  in  1`: one-cycle strobe; timestamp inputs are valid in that cycle.
- `ts_utc_seconds  in  UTC_SECONDS_WIDTH`: UTC second, 0–59.
- `ts_clk_counter  in  COUNT_LAST_SECOND_WIDTH`: cycles since last PPS.
- `ts_drift  in  DRIFT_COUNT_WIDTH`: signed, measured cycles minus nominal for the last second.
- `rd_en  in  1`: pop head entry; ignored when `empty`=1.
- `rd_data  out  64`: head entry, valid while `empty`=0.
- `empty  out  1`: FIFO empty.
- `full  out  1`: FIFO holds FIFO_DEPTH entries.
- `drop_count  out  16`: saturating count of lost timestamps.
- `clear_drops  in  1`: synchronous clear of `drop_count`.
- `busy  out  1`: conversion engine is not IDLE.

## Operation
- Output word layout:
  - [63:58] UTC seconds.
  - [57] `sat`: count ≥ divisor.
  - [56] `drift_bad`: |drift| > DRIFT_LIMIT.
  - [55:30] raw clk count.
  - [29:0] nanoseconds.
- Divisor:
  - NOMINAL_CYCLES_PER_SEC + sign-extended drift, 27-bit unsigned.
  - If |ts_drift| > DRIFT_LIMIT, divisor = NOMINAL and `drift_bad`=1.
- Nanoseconds:
  - floor(count × 1_000_000_000 / divisor).
  - Product is 56 bits; division is restoring, 1 quotient bit per cycle, 30 bits.
  - If count ≥ divisor: ns = 999_999_999, `sat`=1, and the division is still run for fixed latency.
- State machine:
  - IDLE → LOAD on accepted strobe.
  - LOAD: register inputs, product, divisor → DIV.
  - DIV: 30 iterations → PUSH.
  - PUSH: write word to FIFO → IDLE, or → LOAD directly if the pending slot is full.
- Pending slot (1 deep):
  - A `ts_ready` arriving while `busy`=1 is captured into the pending slot.
  - If the pending slot is already occupied, the new strobe is dropped and `drop_count` increments.
  - A strobe in the same cycle the engine returns to IDLE is accepted normally.
- FIFO full at PUSH:
  - If `rd_en`=1 in the same cycle, the push is accepted (pop frees the slot).
  - Otherwise the word is discarded and `drop_count` increments.
- `drop_count` saturates at 0xFFFF. `clear_drops` takes precedence over a simultaneous increment: the result is 0.
- Reset:
  - `rd_data`=0, `empty`=1, `full`=0, `drop_count`=0, `busy`=0.
  - Pointers zero, pending slot cleared, state IDLE.
  - Reset mid-conversion aborts the conversion with no FIFO write.

## Timing
- `ts_ready` sampled high on edge N:
  - LOAD at N+1, DIV N+2..N+31, PUSH at N+32.
  - `empty` falls after edge N+32, i.e. 32 cycles after the strobe edge.
- Back-to-back conversions via the pending slot: 32 cycles apart.
- `busy`=1 from edge N through the PUSH cycle.
- FIFO read:
  - `rd_data` shows the head combinationally from registered storage.
  - Pop takes effect on the edge where `rd_en`=1 and `empty`=0.
- `full` and `empty` are registered and update on the edge after a push or pop.

## Test plan
- count=30_720_000, drift=0, sec=17 → word sec=17, ns=500_000_000, sat=0, drift_bad=0; `empty` low 32 cycles after strobe.
- count=61_439_999, drift=0 → ns=999_999_983; count=30_719_980, drift=−40 → ns=500_000_000.
- count=61_440_000, drift=0 → sat=1, ns=999_999_999; drift=+3000 → drift_bad=1, nominal divisor used.
- Three strobes 2 cycles apart → first two words stored in order; third dropped; `drop_count`=1; `clear_drops` → 0.
- Fill FIFO with 8 words, no reads, push 9th → dropped, `drop_count`=1. Repeat with `rd_en` in the PUSH cycle → accepted, `full` stays 1.
- Assert `rst` at DIV iteration 15 → no FIFO write, all outputs return to reset values; next strobe converts correctly.
